// File: rtl/pipe_chain_pkg.sv
// Shared constants and helpers for the pipe_chain slice.
// Imported by the interface, the stage and the top.
package pipe_chain_pkg;

  localparam int DEF_DATA_W = 32;

  // Width needed to count 0..n valid stages.
  function automatic int occ_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Producer/consumer handshake bundle for pipe_chain.
// master = surrounding logic, slave = the pipeline.
interface pipe_chain_if
  import pipe_chain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_allowin;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_allow;

  modport master (
    output in_valid,
    output in_data,
    output out_allow,
    input  in_allowin,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_allow,
    output in_allowin,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline slot: valid/data register with
// allowin and to_next_valid handshake logic.
module pipe_stage
  import pipe_chain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ready_go,
  input  logic              flush,
  input  logic              next_allowin,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              allowin,
  output logic              to_next_valid
);

  assign allowin = !valid || (ready_go && next_allowin);
  assign to_next_valid = valid && ready_go && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (allowin)
        valid <= in_valid;
      // A flushed slot never captures the incoming payload.
      if (allowin && in_valid && !flush)
        data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// Generic valid/allowin pipeline of NUM_STAGES slots.
// Stage 0 is youngest, stage NUM_STAGES-1 is oldest.
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter  int NUM_STAGES = 5,
  parameter  int DATA_W     = DEF_DATA_W,
  localparam int OCC_W      = occ_w(NUM_STAGES)
) (
  input  logic                         clk,
  input  logic                         reset,
  pipe_chain_if.slave                  bus,
  input  logic [NUM_STAGES-1:0]        stage_ready_go,
  input  logic [NUM_STAGES-1:0]        flush,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic [OCC_W-1:0]             occupancy
);

  // Per-stage nets live in their own generate scope so the
  // allowin ripple is a chain of distinct signals.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stg
    logic              valid;
    logic              allowin;
    logic              to_next_valid;
    logic              in_v;
    logic              next_allowin;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] in_d;

    if (i == 0) begin : g_head
      assign in_v = bus.in_valid;
      assign in_d = bus.in_data;
    end else begin : g_body
      assign in_v = g_stg[i-1].to_next_valid;
      assign in_d = g_stg[i-1].data;
    end

    if (i == NUM_STAGES - 1) begin : g_tail
      assign next_allowin = bus.out_allow;
    end else begin : g_mid
      assign next_allowin = g_stg[i+1].allowin;
    end

    pipe_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_v),
      .in_data      (in_d),
      .ready_go     (stage_ready_go[i]),
      .flush        (flush[i]),
      .next_allowin (next_allowin),
      .valid        (valid),
      .data         (data),
      .allowin      (allowin),
      .to_next_valid(to_next_valid)
    );

    assign stage_valid[i] = valid;
    assign stage_data[i*DATA_W +: DATA_W] = data;
  end

  assign bus.in_allowin = g_stg[0].allowin && !reset;
  assign bus.out_valid  = g_stg[NUM_STAGES-1].to_next_valid;
  assign bus.out_data   = g_stg[NUM_STAGES-1].data;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      occupancy = occupancy + OCC_W'(stage_valid[i]);
  end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed vector bench for pipe_chain (5 stages, 32 bits).
// Inputs change on negedge; outputs compared 1ns later.
module tb_pipe_chain;

  localparam int N = 5;
  localparam int W = 32;
  localparam logic [4:0] ALL = 5'b11111;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic [N-1:0] rg;
    logic [N-1:0] fl;
    logic         oa;
    logic         ia;
    logic         ov;
    logic [W-1:0] od;
    logic [N-1:0] sv;
    logic [2:0]   occ;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   rg;
  logic [N-1:0]   fl;
  logic [N-1:0]   sv;
  logic [N*W-1:0] sd;
  logic [2:0]     occ;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  pipe_chain_if #(.DATA_W(W)) bus ();

  pipe_chain #(
    .NUM_STAGES(N),
    .DATA_W    (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .stage_ready_go(rg),
    .flush         (fl),
    .stage_valid   (sv),
    .stage_data    (sd),
    .occupancy     (occ)
  );

  always #5 clk = ~clk;

  function automatic void add(
    input logic iv, input logic [W-1:0] d,
    input logic [N-1:0] r, input logic [N-1:0] f,
    input logic oa, input logic ia, input logic ov,
    input logic [W-1:0] od, input logic [N-1:0] s,
    input logic [2:0] o
  );
    vec_t v;
    v = '{iv, d, r, f, oa, ia, ov, od, s, o};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [W-1:0] got,
                     input logic [W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d,
                       input logic [N-1:0] r,
                       input logic [N-1:0] f, input logic oa);
    bus.in_valid  = iv;
    bus.in_data   = d;
    rg            = r;
    fl            = f;
    bus.out_allow = oa;
  endtask

  initial begin
    logic [N-1:0] s;
    logic ok;
    int lat;
    bit seen;

    reset = 1'b1;
    drive(1'b0, '0, ALL, '0, 1'b1);

    // Stream 0x1..0xA, all ready: stage j holds item n-1-j.
    for (int n = 0; n < 15; n++) begin
      s = '0;
      for (int j = 0; j < N; j++)
        if (n - 1 - j >= 0 && n - 1 - j <= 9) s[j] = 1'b1;
      add(n < 10, W'(n + 1), ALL, '0, 1'b1,
          1'b1, s[4], W'(n - 4), s, 3'($countones(s)));
    end

    // Full pipe held by out_allow=0 for 3 cycles.
    add(1, 'h10, ALL, '0, 1, 1, 0, 0, 5'b00000, 0);
    add(1, 'h11, ALL, '0, 1, 1, 0, 0, 5'b00001, 1);
    add(1, 'h12, ALL, '0, 1, 1, 0, 0, 5'b00011, 2);
    add(1, 'h13, ALL, '0, 1, 1, 0, 0, 5'b00111, 3);
    add(1, 'h14, ALL, '0, 1, 1, 0, 0, 5'b01111, 4);
    add(0, 0, ALL, '0, 0, 0, 1, 'h10, 5'b11111, 5);
    add(0, 0, ALL, '0, 0, 0, 1, 'h10, 5'b11111, 5);
    add(0, 0, ALL, '0, 0, 0, 1, 'h10, 5'b11111, 5);
    add(0, 0, ALL, '0, 1, 1, 1, 'h10, 5'b11111, 5);
    add(0, 0, ALL, '0, 1, 1, 1, 'h11, 5'b11110, 4);
    add(0, 0, ALL, '0, 1, 1, 1, 'h12, 5'b11100, 3);
    add(0, 0, ALL, '0, 1, 1, 1, 'h13, 5'b11000, 2);
    add(0, 0, ALL, '0, 1, 1, 1, 'h14, 5'b10000, 1);
    add(0, 0, ALL, '0, 1, 1, 0, 0, 5'b00000, 0);

    // Stage 2 stalls 2 cycles with a full pipe: 2 bubbles out.
    add(1, 'h31, ALL, '0, 1, 1, 0, 0, 5'b00000, 0);
    add(1, 'h32, ALL, '0, 1, 1, 0, 0, 5'b00001, 1);
    add(1, 'h33, ALL, '0, 1, 1, 0, 0, 5'b00011, 2);
    add(1, 'h34, ALL, '0, 1, 1, 0, 0, 5'b00111, 3);
    add(1, 'h35, ALL, '0, 1, 1, 0, 0, 5'b01111, 4);
    add(1, 'h36, ALL, '0, 1, 1, 1, 'h31, 5'b11111, 5);
    add(1, 'h37, 5'b11011, '0, 1, 0, 1, 'h32, 5'b11111, 5);
    add(1, 'h37, 5'b11011, '0, 1, 0, 1, 'h33, 5'b10111, 4);
    add(1, 'h37, ALL, '0, 1, 1, 0, 0, 5'b00111, 3);
    add(1, 'h38, ALL, '0, 1, 1, 0, 0, 5'b01111, 4);
    add(0, 0, ALL, '0, 1, 1, 1, 'h34, 5'b11111, 5);
    add(0, 0, ALL, '0, 1, 1, 1, 'h35, 5'b11110, 4);
    add(0, 0, ALL, '0, 1, 1, 1, 'h36, 5'b11100, 3);
    add(0, 0, ALL, '0, 1, 1, 1, 'h37, 5'b11000, 2);
    add(0, 0, ALL, '0, 1, 1, 1, 'h38, 5'b10000, 1);
    add(0, 0, ALL, '0, 1, 1, 0, 0, 5'b00000, 0);

    // Flush the three youngest of a held full pipe.
    add(1, 'h20, ALL, '0, 1, 1, 0, 0, 5'b00000, 0);
    add(1, 'h21, ALL, '0, 1, 1, 0, 0, 5'b00001, 1);
    add(1, 'h22, ALL, '0, 1, 1, 0, 0, 5'b00011, 2);
    add(1, 'h23, ALL, '0, 1, 1, 0, 0, 5'b00111, 3);
    add(1, 'h24, ALL, '0, 1, 1, 0, 0, 5'b01111, 4);
    add(0, 0, ALL, '0, 0, 0, 1, 'h20, 5'b11111, 5);
    add(0, 0, ALL, 5'b00111, 0, 0, 1, 'h20, 5'b11111, 5);
    add(0, 0, ALL, '0, 1, 1, 1, 'h20, 5'b11000, 2);
    add(0, 0, ALL, '0, 1, 1, 1, 'h21, 5'b10000, 1);
    add(0, 0, ALL, '0, 1, 1, 0, 0, 5'b00000, 0);

    // Flush stage 1 while stage 0 hands off into it.
    add(1, 'h41, ALL, '0, 1, 1, 0, 0, 5'b00000, 0);
    add(1, 'h42, ALL, '0, 1, 1, 0, 0, 5'b00001, 1);
    add(0, 0, ALL, 5'b00010, 1, 1, 0, 0, 5'b00011, 2);
    add(0, 0, ALL, '0, 1, 1, 0, 0, 5'b00000, 0);

    // Reset state.
    #1;
    chk("rst_in_allowin", W'(bus.in_allowin), 0);
    chk("rst_out_valid", W'(bus.out_valid), 0);
    chk("rst_stage_valid", W'(sv), 0);
    chk("rst_stage_data", W'(|sd), 0);
    chk("rst_occupancy", W'(occ), 0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].iv, vecs[k].d, vecs[k].rg,
            vecs[k].fl, vecs[k].oa);
      #1;
      ok = (bus.in_allowin === vecs[k].ia) &&
           (bus.out_valid === vecs[k].ov) &&
           (sv === vecs[k].sv) &&
           (occ === vecs[k].occ) &&
           (!vecs[k].ov || bus.out_data === vecs[k].od);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display({"FAIL vec%0d: got ia=%b ov=%b od=%h sv=%b ",
                  "occ=%0d, want ia=%b ov=%b od=%h sv=%b occ=%0d"},
                 k, bus.in_allowin, bus.out_valid, bus.out_data,
                 sv, occ, vecs[k].ia, vecs[k].ov, vecs[k].od,
                 vecs[k].sv, vecs[k].occ);
      end
    end

    // Asynchronous reset with four payloads in flight.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, W'('h50 + k), ALL, '0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, '0, ALL, '0, 1'b0);
    #1;
    chk("pre_rst_occupancy", W'(occ), 4);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_in_allowin", W'(bus.in_allowin), 0);
    chk("arst_out_valid", W'(bus.out_valid), 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_stage_valid", W'(sv), 0);
    chk("arst_stage_data", W'(|sd), 0);
    chk("arst_occupancy", W'(occ), 0);

    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 'h55, ALL, '0, 1'b1);
    #1;
    chk("post_rst_in_allowin", W'(bus.in_allowin), 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      drive(1'b0, '0, ALL, '0, 1'b1);
      lat++;
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("post_rst_latency", W'(lat), 5);
    chk("post_rst_out_data", bus.out_data, 'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline stages (legal 1..8).
REQ-002 SHALL have parameter DATA_W, default 32, payload width per stage (legal >= 1).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer offers a payload to stage 0.
REQ-006 SHALL have port in_data  input  DATA_W  payload offered to stage 0.
REQ-007 SHALL have port in_allowin  output  1  stage 0 accepts this cycle.
REQ-008 SHALL have port stage_ready_go  input  NUM_STAGES  bit i: stage i has finished its work.
REQ-009 SHALL have port flush  input  NUM_STAGES  bit i: kill the contents of stage i.
REQ-010 SHALL have port out_allow  input  1  consumer accepts from the last stage.
REQ-011 SHALL have port out_valid  output  1  last stage presents a payload.
REQ-012 SHALL have port out_data  output  DATA_W  payload of the last stage.
REQ-013 SHALL have port stage_valid  output  NUM_STAGES  per-stage valid flags, for bypass and hazard logic.
REQ-014 SHALL have port stage_data  output  NUM_STAGES*DATA_W  per-stage payloads; stage i occupies bits [i*DATA_W +: DATA_W].
REQ-015 SHALL have port occupancy  output  clog2(NUM_STAGES+1)  count of valid stages.

Function
REQ-016 Stage 0 SHALL be youngest and stage NUM_STAGES-1 oldest; each stage SHALL hold one valid bit and one DATA_W payload register.
REQ-017 allowin_i SHALL equal !valid_i || (stage_ready_go[i] && allowin_{i+1}), with allowin_{NUM_STAGES} = out_allow.
REQ-018 to_next_valid_i SHALL equal valid_i && stage_ready_go[i] && !flush[i].
REQ-019 The input of stage 0 SHALL be in_valid; the input of stage i>0 SHALL be to_next_valid_{i-1}.
REQ-020 Per edge: if flush[i], valid_i <= 0; else if allowin_i, valid_i <= input_i; else hold.
REQ-021 data_i SHALL load only when allowin_i && input_i && !flush[i]; otherwise data_i SHALL hold.
REQ-022 in_allowin SHALL equal allowin_0 && !reset; out_valid SHALL equal to_next_valid_{NUM_STAGES-1}; out_data SHALL equal data_{NUM_STAGES-1}.
REQ-023 Latency: a payload accepted in cycle c with all ready_go=1 and out_allow=1 SHALL appear on out_data with out_valid=1 in cycle c+NUM_STAGES; throughput SHALL be 1 payload per cycle.
REQ-024 Stall: when stage_ready_go[i]=0, stages i..0 SHALL hold once full; stages above i SHALL continue draining, and the gap SHALL appear as a bubble.
REQ-025 Full pipe with out_allow=0: all stages SHALL hold, in_allowin SHALL be 0, and no payload SHALL be lost or duplicated.
REQ-026 Simultaneous flush[i] and upstream hand-off into stage i: the incoming payload SHALL be discarded and stage i SHALL be empty next cycle.
REQ-027 flush[i] while stage i is stalled SHALL still clear it; stage i+1 SHALL NOT receive it that cycle.
REQ-028 Simultaneous drain and fill of the same stage SHALL be lossless; occupancy SHALL equal the popcount of the valid bits, registered-state-derived.

Reset
REQ-029 Asserting reset SHALL immediately clear all valid bits and payloads to 0, including mid-transfer.
REQ-030 While reset is asserted, out_valid, stage_valid, stage_data, out_data and occupancy SHALL be 0, and in_allowin SHALL be 0.
REQ-031 On the first edge after reset deasserts, stage 0 SHALL accept in_valid.

Structure
REQ-032 The sub-module pipe_stage SHALL contain one valid/data register plus its allowin and to_next_valid logic, instantiated NUM_STAGES times by generate.
REQ-033 The occupancy-width clog2 helper and the default DATA_W (32) SHALL live in the shared cpu package/header; no typedefs are required.

Verification (NUM_STAGES=5, DATA_W=32)
REQ-034 Stream 0x1..0xA, one per cycle, all ready_go=1, out_allow=1 -> out_data 0x1..0xA in order, first in cycle c+5, no gaps.
REQ-035 Full pipe 0x10..0x14, out_allow=0 for 3 cycles -> in_allowin=0, occupancy=5, out_data holds 0x10; on release, 0x10..0x14 drain in order.
REQ-036 stage_ready_go[2]=0 for 2 cycles mid-stream -> exactly 2 bubbles at the output; no loss, no duplication.
REQ-037 Full pipe 0x20..0x24 with flush=5'b00111 for one cycle -> next cycle stage_valid=5'b11000, occupancy=2, only 0x20 and 0x21 (oldest) emerge.
REQ-038 Reset asserted asynchronously between edges with occupancy=4 -> outputs zero before the next edge, in_allowin=0; after release, 0x55 accepted and out in 5 cycles.
